// File: rtl/gpzda_pkg.sv
// Shared constants, types and helpers for the $GPZDA sentence emitter.
package gpzda_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned N_WITH_CS = 38;
    localparam int unsigned N_NO_CS   = 35;

    localparam logic [BYTE_W-1:0] ASCII_DOLLAR = 8'h24;
    localparam logic [BYTE_W-1:0] ASCII_COMMA  = 8'h2C;
    localparam logic [BYTE_W-1:0] ASCII_DOT    = 8'h2E;
    localparam logic [BYTE_W-1:0] ASCII_STAR   = 8'h2A;
    localparam logic [BYTE_W-1:0] ASCII_CR     = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF     = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_ZERO   = 8'h30;

    // Byte positions inside the sentence
    localparam logic [IDX_W-1:0] IDX_C0       = 6'd6;
    localparam logic [IDX_W-1:0] IDX_TIME     = 6'd7;
    localparam logic [IDX_W-1:0] IDX_DOT      = 6'd13;
    localparam logic [IDX_W-1:0] IDX_FRAC     = 6'd14;
    localparam logic [IDX_W-1:0] IDX_C1       = 6'd16;
    localparam logic [IDX_W-1:0] IDX_DAY      = 6'd17;
    localparam logic [IDX_W-1:0] IDX_C2       = 6'd19;
    localparam logic [IDX_W-1:0] IDX_MON      = 6'd20;
    localparam logic [IDX_W-1:0] IDX_C3       = 6'd22;
    localparam logic [IDX_W-1:0] IDX_YEAR     = 6'd23;
    localparam logic [IDX_W-1:0] IDX_C4       = 6'd27;
    localparam logic [IDX_W-1:0] IDX_ZH       = 6'd28;
    localparam logic [IDX_W-1:0] IDX_C5       = 6'd30;
    localparam logic [IDX_W-1:0] IDX_ZM       = 6'd31;
    localparam logic [IDX_W-1:0] IDX_CS_FIRST = 6'd1;
    localparam logic [IDX_W-1:0] IDX_CS_LAST  = 6'd32;
    localparam logic [IDX_W-1:0] IDX_STAR     = 6'd33;
    localparam logic [IDX_W-1:0] IDX_CS_HI    = 6'd34;
    localparam logic [IDX_W-1:0] IDX_CS_LO    = 6'd35;
    localparam logic [IDX_W-1:0] IDX_CR_CS    = 6'd36;
    localparam logic [IDX_W-1:0] IDX_LF_CS    = 6'd37;
    localparam logic [IDX_W-1:0] IDX_CR_NO_CS = 6'd33;
    localparam logic [IDX_W-1:0] IDX_LF_NO_CS = 6'd34;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // BCD digit to ASCII; nibbles above 9 pass through unchecked
    function automatic logic [BYTE_W-1:0] bcd_to_ascii(input logic [3:0] d);
        return ASCII_ZERO | {4'h0, d};
    endfunction

    // Nibble to uppercase hex ASCII
    function automatic logic [BYTE_W-1:0] nibble_to_hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_ZERO | {4'h0, n};
        end
        return BYTE_W'(8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/nmea_checksum_acc.sv
// Running 8-bit XOR over the bytes of one NMEA sentence.
module nmea_checksum_acc
    import gpzda_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] xor_out
);

    // Accumulate on enable, restart on clear
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            xor_out <= '0;
        end else if (en) begin
            xor_out <= xor_out ^ byte_in;
        end
    end

endmodule

// File: rtl/gpzda_emitter.sv
// Serialises one "$GPZDA,hhmmss.00,dd,mm,yyyy,ZH,ZM*CS\r\n" sentence per start
// over a valid/ready byte stream. Define NMEA_CHECKSUM_EN to include "*CS";
// without it the sentence ends "ZM\r\n" and no checksum logic is built.
module gpzda_emitter
    import gpzda_pkg::*;
#(
    parameter int unsigned B       = 8,
    parameter logic [47:0] HEADER  = "$GPZDA",
    parameter logic [7:0]  ZONE_HH = 8'h00,
    parameter logic [7:0]  ZONE_MM = 8'h00
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [23:0]  time_bcd,
    input  logic [31:0]  date_bcd,
    output logic [B-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         done
);

`ifdef NMEA_CHECKSUM_EN
    localparam int unsigned N = N_WITH_CS;
`else
    localparam int unsigned N = N_NO_CS;
`endif
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  sel_idx;
    logic [23:0]       time_q;
    logic [31:0]       date_q;
    logic [BYTE_W-1:0] next_byte;
    logic              hs;
    logic              start_ok;
    logic              last_byte;

    assign hs        = valid & ready;
    // A start in the done cycle is dropped so one pulse never yields two sentences
    assign start_ok  = (state == ST_IDLE) && start && !done;
    assign last_byte = (index == IDX_LAST);
    // Byte to load next: first byte on start, following byte on handshake
    assign sel_idx   = start_ok ? '0 : index + IDX_W'(1);

`ifdef NMEA_CHECKSUM_EN
    logic [BYTE_W-1:0] cs_value;
    logic              cs_en;

    // XOR covers bytes 1..32, taken as each is accepted
    assign cs_en = (state == ST_SEND) && hs &&
                   (index >= IDX_CS_FIRST) && (index <= IDX_CS_LAST);

    nmea_checksum_acc u_checksum (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_ok),
        .en      (cs_en),
        .byte_in (BYTE_W'(data)),
        .xor_out (cs_value)
    );
`endif

    // Sentence byte map, selected by position
    always_comb begin
        next_byte = '0;
        case (sel_idx)
            6'd0:                   next_byte = HEADER[47:40];
            6'd1:                   next_byte = HEADER[39:32];
            6'd2:                   next_byte = HEADER[31:24];
            6'd3:                   next_byte = HEADER[23:16];
            6'd4:                   next_byte = HEADER[15:8];
            6'd5:                   next_byte = HEADER[7:0];
            IDX_C0, IDX_C1, IDX_C2,
            IDX_C3, IDX_C4, IDX_C5: next_byte = ASCII_COMMA;
            IDX_TIME:               next_byte = bcd_to_ascii(time_q[23:20]);
            IDX_TIME + 6'd1:        next_byte = bcd_to_ascii(time_q[19:16]);
            IDX_TIME + 6'd2:        next_byte = bcd_to_ascii(time_q[15:12]);
            IDX_TIME + 6'd3:        next_byte = bcd_to_ascii(time_q[11:8]);
            IDX_TIME + 6'd4:        next_byte = bcd_to_ascii(time_q[7:4]);
            IDX_TIME + 6'd5:        next_byte = bcd_to_ascii(time_q[3:0]);
            IDX_DOT:                next_byte = ASCII_DOT;
            IDX_FRAC,
            IDX_FRAC + 6'd1:        next_byte = ASCII_ZERO;
            IDX_DAY:                next_byte = bcd_to_ascii(date_q[31:28]);
            IDX_DAY + 6'd1:         next_byte = bcd_to_ascii(date_q[27:24]);
            IDX_MON:                next_byte = bcd_to_ascii(date_q[23:20]);
            IDX_MON + 6'd1:         next_byte = bcd_to_ascii(date_q[19:16]);
            IDX_YEAR:               next_byte = bcd_to_ascii(date_q[15:12]);
            IDX_YEAR + 6'd1:        next_byte = bcd_to_ascii(date_q[11:8]);
            IDX_YEAR + 6'd2:        next_byte = bcd_to_ascii(date_q[7:4]);
            IDX_YEAR + 6'd3:        next_byte = bcd_to_ascii(date_q[3:0]);
            IDX_ZH:                 next_byte = bcd_to_ascii(ZONE_HH[7:4]);
            IDX_ZH + 6'd1:          next_byte = bcd_to_ascii(ZONE_HH[3:0]);
            IDX_ZM:                 next_byte = bcd_to_ascii(ZONE_MM[7:4]);
            IDX_ZM + 6'd1:          next_byte = bcd_to_ascii(ZONE_MM[3:0]);
`ifdef NMEA_CHECKSUM_EN
            IDX_STAR:               next_byte = ASCII_STAR;
            IDX_CS_HI:              next_byte = nibble_to_hex_ascii(cs_value[7:4]);
            IDX_CS_LO:              next_byte = nibble_to_hex_ascii(cs_value[3:0]);
            IDX_CR_CS:              next_byte = ASCII_CR;
            IDX_LF_CS:              next_byte = ASCII_LF;
`else
            IDX_CR_NO_CS:           next_byte = ASCII_CR;
            IDX_LF_NO_CS:           next_byte = ASCII_LF;
`endif
            default:                next_byte = '0;
        endcase
    end

    // Sentence FSM with registered stream outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            index  <= '0;
            data   <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            time_q <= '0;
            date_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        time_q <= time_bcd;
                        date_q <= date_bcd;
                        index  <= '0;
                        data   <= B'(next_byte);
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (last_byte) begin
                            state <= ST_IDLE;
                            index <= '0;
                            data  <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= sel_idx;
                            data  <= B'(next_byte);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpzda_emitter.sv
// Self-checking bench for gpzda_emitter: directed cases plus random fields and
// random back-pressure, checked against a string-level sentence model.
module tb_gpzda_emitter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [23:0] time_bcd;
    logic [31:0] date_bcd;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    gpzda_emitter dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .time_bcd (time_bcd),
        .date_bcd (date_bcd),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference sentence from the field values, built as text
    task automatic build_expected(input logic [23:0] t, input logic [31:0] d);
        string body;
        logic [7:0] cs;
        body = $sformatf("GPZDA,%06h.00,%02h,%02h,%04h,00,00", t, d[31:24], d[23:16], d[15:0]);
        exp_q.delete();
        exp_q.push_back(8'h24);
        cs = 8'h00;
        for (int i = 0; i < body.len(); i++) begin
            exp_q.push_back(body[i]);
            cs = cs ^ body[i];
        end
`ifdef NMEA_CHECKSUM_EN
        exp_q.push_back(8'h2A);
        exp_q.push_back(hex_char(cs[7:4]));
        exp_q.push_back(hex_char(cs[3:0]));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        string hexdig;
        hexdig = "0123456789ABCDEF";
        return hexdig[n];
    endfunction

    function automatic logic [23:0] rand_time();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    function automatic logic [31:0] rand_date();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic launch(input logic [23:0] t, input logic [31:0] d);
        @(negedge clock);
        time_bcd = t;
        date_bcd = d;
        start    = 1'b1;
        build_expected(t, d);
    endtask

    // Sink: collect bytes, optionally stall / poke start / scramble fields / reset
    task automatic collect(input string tag, input int budget, input int stall_idx,
                           input int stall_len, input bit rand_ready, input int poke_idx,
                           input bit poke_done, input bit scramble, input int reset_idx);
        int stall_left;
        bit prev_stall;
        logic [7:0] prev_data;
        int hold_bad;
        int busy_bad;
        int last_acc;
        int done_cyc;
        int first_valid;
        int dones;
        int nbad;
        stall_left  = stall_len;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        hold_bad    = 0;
        busy_bad    = 0;
        last_acc    = -10;
        done_cyc    = -1;
        first_valid = -1;
        dones       = 0;
        got_q.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (prev_stall && (valid !== 1'b1 || data !== prev_data)) hold_bad++;
            prev_stall = 1'b0;
            if (done === 1'b1) begin
                dones++;
                done_cyc = c;
                if (poke_done) start = 1'b1;
            end
            ready = 1'b1;
            if (valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (busy !== 1'b1) busy_bad++;
                if (reset_idx >= 0 && got_q.size() == reset_idx) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    chk({tag, "_rst_valid"}, 64'(valid), 64'(0));
                    chk({tag, "_rst_busy"}, 64'(busy), 64'(0));
                    chk({tag, "_rst_done"}, 64'(done), 64'(0));
                    return;
                end
                if (stall_left > 0 && got_q.size() == stall_idx) begin
                    ready = 1'b0;
                    stall_left--;
                end else if (rand_ready && $urandom_range(0, 3) == 0) begin
                    ready = 1'b0;
                end
                if (got_q.size() == poke_idx) start = 1'b1;
                if (scramble) begin
                    time_bcd = 24'($urandom);
                    date_bcd = $urandom;
                end
                if (ready) begin
                    got_q.push_back(data);
                    last_acc = c;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = data;
                end
            end
        end
        ready = 1'b1;
        nbad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) nbad++;
        end
        chk({tag, "_first_valid_cycle"}, 64'(first_valid), 64'(0));
        chk({tag, "_length"}, 64'(got_q.size()), 64'(exp_q.size()));
        chk({tag, "_bad_bytes"}, 64'(nbad), 64'(0));
        chk({tag, "_done_pulses"}, 64'(dones), 64'(1));
        chk({tag, "_done_timing"}, 64'(done_cyc), 64'(last_acc + 1));
        chk({tag, "_hold_bad"}, 64'(hold_bad), 64'(0));
        chk({tag, "_busy_bad"}, 64'(busy_bad), 64'(0));
    endtask

    // Compare captured stream against a literal sentence
    task automatic chk_literal(input string tag, input string lit);
        int nbad;
        nbad = 0;
        for (int i = 0; i < lit.len(); i++) begin
            if (i >= got_q.size() || got_q[i] !== lit[i]) nbad++;
        end
        chk({tag, "_literal"}, 64'(nbad), 64'(0));
    endtask

    initial begin
        string lit;
`ifdef NMEA_CHECKSUM_EN
        lit = "$GPZDA,123456.00,09,10,2021,00,00*68\r\n";
`else
        lit = "$GPZDA,123456.00,09,10,2021,00,00\r\n";
`endif
        reset    = 1'b1;
        start    = 1'b0;
        ready    = 1'b1;
        time_bcd = '0;
        date_bcd = '0;
        repeat (3) @(negedge clock);
        chk("reset_valid", 64'(valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_data", 64'(data), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic sentence, continuous ready
        launch(24'h123456, 32'h09102021);
        collect("t1", 60, -1, 0, 1'b0, -1, 1'b0, 1'b0, -1);
        chk_literal("t1", lit);

        // Back-pressure for 3 cycles on byte 10
        launch(24'h123456, 32'h09102021);
        collect("t2", 60, 10, 3, 1'b0, -1, 1'b0, 1'b0, -1);
        chk_literal("t2", lit);

        // Stray starts mid-sentence and in the done cycle
        launch(24'h123456, 32'h09102021);
        collect("t3", 70, -1, 0, 1'b0, 5, 1'b1, 1'b0, -1);
        chk("t3_idle_after", 64'(valid), 64'(0));

        // Reset at byte 20, then a fresh sentence
        launch(24'h123456, 32'h09102021);
        collect("t4a", 60, -1, 0, 1'b0, -1, 1'b0, 1'b0, 20);
        launch(24'h000000, 32'h01012000);
        collect("t4b", 60, -1, 0, 1'b0, -1, 1'b0, 1'b0, -1);

        // Inputs change while busy
        launch(24'h235959, 32'h31121999);
        collect("t6", 60, -1, 0, 1'b0, -1, 1'b0, 1'b1, -1);

        // Random fields with random back-pressure
        for (int k = 0; k < 5; k++) begin
            launch(rand_time(), rand_date());
            collect($sformatf("rnd%0d", k), 200, -1, 0, 1'b1, -1, 1'b0, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
